// File: rtl/lf_sub_pipe.sv
// lf_sub_pipe: two-stage pipelined Ladner-Fischer borrow-lookahead subtractor.
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin) as
// a + ~b + ~bin through a prefix tree. Nodes 0..WIDTH of the tree are the
// injected carry-in (node 0) followed by one node per operand bit.
// The odd nodes form the Ladner-Fischer core, and a final grey-cell level
// fills in the even nodes.
// Stage 1 covers pre-computation and the first half of the prefix levels.
// Stage 2 covers the remaining levels, the fix-up level and the sum.
// Optional feature macro: LF_SUB_FLAGS_EN adds the registered ovf/zero flags.
module lf_sub_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef LF_SUB_FLAGS_EN
    output logic             bout,
    output logic             ovf,
    output logic             zero
`else
    output logic             bout
`endif
);

    localparam int N  = WIDTH + 1;          // prefix nodes incl. carry-in
    localparam int L  = $clog2(N);          // Ladner-Fischer levels
    localparam int H  = (L + 1) / 2;        // levels evaluated in stage 1

    // One Ladner-Fischer level over the node vectors, returned as {g, p}.
    // Level 1 pairs each odd node with its even neighbour. Later levels run
    // a Sklansky-style prefix over the odd nodes only, using odd-node index m.
    function automatic logic [2*N-1:0] lf_level(input int k,
                                                input logic [N-1:0] g,
                                                input logic [N-1:0] p);
        logic [N-1:0] go;
        logic [N-1:0] po;
        int           j;
        int           m;
        int           mp;
        go = g;
        po = p;
        for (int i = 1; i < N; i++) begin
            j = -1;
            if ((i % 2) == 1) begin
                if (k == 1) begin
                    j = i - 1;
                end else begin
                    m = (i - 1) / 2;
                    if (((m >> (k - 2)) & 1) == 1) begin
                        mp = ((m >> (k - 2)) << (k - 2)) - 1;
                        j  = 2 * mp + 1;
                    end else begin
                        j = -1;
                    end
                end
            end else begin
                j = -1;
            end
            if (j >= 0) begin
                go[i] = g[i] | (p[i] & g[j]);
                po[i] = p[i] & p[j];
            end else begin
                go[i] = g[i];
                po[i] = p[i];
            end
        end
        return {go, po};
    endfunction

    // Grey-cell fix-up: each even node takes the completed prefix of the
    // odd node just below it.
    function automatic logic [N-1:0] lf_fixup(input logic [N-1:0] g,
                                              input logic [N-1:0] p);
        logic [N-1:0] go;
        go = g;
        for (int i = 2; i < N; i += 2) begin
            go[i] = g[i] | (p[i] & g[i-1]);
        end
        return go;
    endfunction

    logic             r_s1_v;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_s1_pbit;
    logic [N-1:0]     r_s1_g;
    logic [N-1:0]     r_s1_p;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef LF_SUB_FLAGS_EN
    logic             r_s1_a_msb;
    logic             r_s1_b_msb;
    logic             r_ovf;
    logic             r_zero;
`endif

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_pbit;
    logic [N-1:0]     w_s1_g;
    logic [N-1:0]     w_s1_p;
    logic [WIDTH-1:0] w_diff;
    logic             w_bout;

    // Handshake: in_ready also opens when the output is being drained.
    assign in_ready  = ~rst & (~r_s1_v | ~r_s2_v | out_ready);
    assign w_s1_load = in_valid & in_ready;
    assign w_s2_load = r_s1_v & (~r_s2_v | out_ready);

    // Stage 1 combinational: propagate/generate with carry-in on node 0,
    // then the first H prefix levels.
    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        w_pbit = a ^ ~b;
        g      = {a & ~b, ~bin};
        p      = {w_pbit, 1'b0};
        for (int k = 1; k <= H; k++) begin
            {g, p} = lf_level(k, g, p);
        end
        w_s1_g = g;
        w_s1_p = p;
    end

    // Stage 2 combinational: remaining prefix levels, fix-up, difference.
    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        g = r_s1_g;
        p = r_s1_p;
        for (int k = H + 1; k <= L; k++) begin
            {g, p} = lf_level(k, g, p);
        end
        g      = lf_fixup(g, p);
        w_diff = r_s1_pbit ^ g[WIDTH-1:0];
        w_bout = ~g[WIDTH];
    end

    // Pipeline registers and valid bits; reset discards in-flight operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s1_pbit <= {WIDTH{1'b0}};
            r_s1_g    <= {N{1'b0}};
            r_s1_p    <= {N{1'b0}};
            r_diff    <= {WIDTH{1'b0}};
            r_bout    <= 1'b0;
`ifdef LF_SUB_FLAGS_EN
            r_s1_a_msb <= 1'b0;
            r_s1_b_msb <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
`endif
        end else begin
            if (w_s1_load) begin
                r_s1_v    <= 1'b1;
                r_s1_pbit <= w_pbit;
                r_s1_g    <= w_s1_g;
                r_s1_p    <= w_s1_p;
`ifdef LF_SUB_FLAGS_EN
                r_s1_a_msb <= a[WIDTH-1];
                r_s1_b_msb <= b[WIDTH-1];
`endif
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end else begin
                r_s1_v <= r_s1_v;
            end

            if (w_s2_load) begin
                r_s2_v <= 1'b1;
                r_diff <= w_diff;
                r_bout <= w_bout;
`ifdef LF_SUB_FLAGS_EN
                r_ovf  <= (r_s1_a_msb ^ r_s1_b_msb) & (w_diff[WIDTH-1] ^ r_s1_a_msb);
                r_zero <= (w_diff == {WIDTH{1'b0}});
`endif
            end else if (out_ready) begin
                r_s2_v <= 1'b0;
            end else begin
                r_s2_v <= r_s2_v;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign diff      = r_diff;
    assign bout      = r_bout;
`ifdef LF_SUB_FLAGS_EN
    assign ovf       = r_ovf;
    assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_lf_sub_pipe.sv
// Testbench for lf_sub_pipe (WIDTH=12): directed vectors, back-pressure,
// mid-operation reset and a randomized handshake run against an
// arithmetic reference model. Flags are checked when LF_SUB_FLAGS_EN is set.
module tb_lf_sub_pipe;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic [W+2:0] obs;
    logic [W+2:0] mask;

    int n_vec = 0;
    int n_err = 0;

`ifdef LF_SUB_FLAGS_EN
    logic ovf;
    logic zero;
    lf_sub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero));
    assign obs  = {ovf, zero, bout, diff};
    assign mask = {(W+3){1'b1}};
`else
    lf_sub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout));
    assign obs  = {2'b00, bout, diff};
    assign mask = {2'b00, {(W+1){1'b1}}};
`endif

    always #5 clk = ~clk;

    // Reference: {ovf, zero, bout, diff} from integer arithmetic.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] ra,
                                             input logic [W-1:0] rb,
                                             input logic rbin);
        int ua, ub, ud, sa, sb, sd;
        logic [W-1:0] d;
        logic bo, ov, zr;
        ua = int'(ra);
        ub = int'(rb);
        ud = ua - ub - int'(rbin);
        bo = (ud < 0);
        d  = W'(ud + (1 << W));
        sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        sd = sa - sb - int'(rbin);
        ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
        zr = (d == '0);
        return {ov, zr, bo, d};
    endfunction

    // Drive inputs after the falling edge, then settle before sampling.
    task automatic step(input logic iv, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ibin,
                        input logic ordy);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; bin = ibin; out_ready = ordy;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step(1'b1, 12'h0AB, 12'h012, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_vec++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_outputs got %h want 0", obs); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    // Result visible two cycles after presentation, not one.
    task automatic test_directed;
        logic [W-1:0] ta [4] = '{12'h000, 12'h800, 12'h123, 12'h123};
        logic [W-1:0] tb [4] = '{12'h001, 12'h001, 12'h123, 12'h123};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] td [4] = '{12'hFFF, 12'h7FF, 12'h000, 12'hFFF};
        logic [W+2:0] e;
        for (int i = 0; i < 4; i++) begin
            e = ref_sub(ta[i], tb[i], tc[i]);
            step(1'b1, ta[i], tb[i], tc[i], 1'b1);
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_accept got %b want 1", i, in_ready); end
            step(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early got %b want 0", i, out_valid); end
            step(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (out_valid !== 1'b1 || obs !== (e & mask) || diff !== td[i]) begin
                n_err++;
                $display("FAIL dir%0d_result got v=%b %h want v=1 %h diff %h", i, out_valid, obs, e & mask, td[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] oa [5];
        logic [W-1:0] ob [5];
        logic         oc [5];
        logic [W+2:0] e;
        int idx = 0;
        for (int i = 0; i < 5; i++) begin
            oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
        end
        for (int c = 0; c < 4; c++) begin
            step(idx < 5, oa[idx % 5], ob[idx % 5], oc[idx % 5], 1'b0);
            n_vec++;
            if (in_ready !== (c < 2)) begin n_err++; $display("FAIL bp_in_ready c%0d got %b want %b", c, in_ready, c < 2); end
            if (c >= 2) begin
                e = ref_sub(oa[0], ob[0], oc[0]);
                n_vec++;
                if (out_valid !== 1'b1 || obs !== (e & mask)) begin
                    n_err++; $display("FAIL bp_stall c%0d got v=%b %h want v=1 %h", c, out_valid, obs, e & mask);
                end
            end
            if (in_valid && in_ready) idx++;
        end
        n_vec++;
        if (idx !== 2) begin n_err++; $display("FAIL bp_buffered got %0d want 2", idx); end
        for (int c = 0; c < 5; c++) begin
            step(idx < 5, oa[idx % 5], ob[idx % 5], oc[idx % 5], 1'b1);
            e = ref_sub(oa[c], ob[c], oc[c]);
            n_vec++;
            if (out_valid !== 1'b1 || obs !== (e & mask)) begin
                n_err++; $display("FAIL bp_drain%0d got v=%b %h want v=1 %h", c, out_valid, obs, e & mask);
            end
            if (in_valid && in_ready) idx++;
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if (idx !== 5 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_end got idx=%0d v=%b want 5 0", idx, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [W+2:0] e;
        int outs = 0;
        step(1'b1, 12'h555, 12'h0F0, 1'b0, 1'b0);
        step(1'b1, 12'h001, 12'h002, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rm_full got v=%b r=%b want 1 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_rdy_in_rst got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rm_after got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        e = ref_sub(12'h3C7, 12'h5A1, 1'b1);
        step(1'b1, 12'h3C7, 12'h5A1, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid) begin
                outs++;
                n_vec++;
                if (obs !== (e & mask)) begin n_err++; $display("FAIL rm_new got %h want %h", obs, e & mask); end
            end
        end
        n_vec++;
        if (outs !== 1) begin n_err++; $display("FAIL rm_count got %0d want 1", outs); end
    endtask

    task automatic test_random;
        logic [W+2:0] q[$];
        logic [W+2:0] e;
        logic [W+2:0] prev_obs = '0;
        logic         prev_stall = 1'b0;
        int acc = 0;
        int outs = 0;
        int cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            cyc++;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || obs !== prev_obs) begin
                    n_err++; $display("FAIL rnd_hold got v=%b %h want v=1 %h", out_valid, obs, prev_obs);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra got %h want none", obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== (e & mask)) begin n_err++; $display("FAIL rnd_data got %h want %h", obs, e & mask); end
                end
                outs++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(a, b, bin));
                acc++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra got %h want none", obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== (e & mask)) begin n_err++; $display("FAIL rnd_data got %h want %h", obs, e & mask); end
                end
                outs++;
            end
        end
        n_vec++;
        if (acc !== 10000 || outs !== acc || q.size() != 0) begin
            n_err++; $display("FAIL rnd_count got in=%0d out=%0d left=%0d want 10000 equal 0", acc, outs, q.size());
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
